// File: rtl/button_debouncer.sv
// Push-button input path: synchronises the raw pin into clk, filters contact bounce,
// and produces a clean level, press/release pulses, an LED toggle and a press counter.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  output logic             btn_level,
  output logic             btn_press,
  output logic             btn_release,
  output logic             led_toggle,
  output logic [CNT_W-1:0] press_count
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE_LOW   = 2'd0;
  localparam logic [1:0] CHECK_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH  = 2'd2;
  localparam logic [1:0] CHECK_LOW  = 2'd3;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;

  logic [1:0]       state_r,   state_s;
  logic [CW-1:0]    cnt_r,     cnt_s;
  logic             level_r,   level_s;
  logic             press_r,   press_s;
  logic             release_r, release_s;
  logic             led_r,     led_s;
  logic [CNT_W-1:0] count_r,   count_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain: the only place btn_in is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], btn_in};
    end
  end

  // Debounce FSM next-state and registered-output next values.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    level_s   = level_r;
    press_s   = 1'b0;
    release_s = 1'b0;
    led_s     = led_r;
    count_s   = count_r;
    case (state_r)
      IDLE_LOW: begin
        if (sync_s) begin
          state_s = CHECK_HIGH;
          cnt_s   = CW'(1);
        end else begin
          cnt_s = '0;
        end
      end
      CHECK_HIGH: begin
        if (!sync_s) begin
          state_s = IDLE_LOW;
          cnt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_s = IDLE_HIGH;
          cnt_s   = '0;
          level_s = 1'b1;
          press_s = 1'b1;
          led_s   = ~led_r;
          count_s = count_r + CNT_W'(1);
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      IDLE_HIGH: begin
        if (!sync_s) begin
          state_s = CHECK_LOW;
          cnt_s   = CW'(1);
        end else begin
          cnt_s = '0;
        end
      end
      CHECK_LOW: begin
        // A high sample here is bounce back to the accepted level; no release pulse.
        if (sync_s) begin
          state_s = IDLE_HIGH;
          cnt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_s   = IDLE_LOW;
          cnt_s     = '0;
          level_s   = 1'b0;
          release_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = IDLE_LOW;
        cnt_s   = '0;
      end
    endcase
  end

  // FSM state, stability counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE_LOW;
      cnt_r     <= '0;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      led_r     <= 1'b0;
      count_r   <= '0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      level_r   <= level_s;
      press_r   <= press_s;
      release_r <= release_s;
      led_r     <= led_s;
      count_r   <= count_s;
    end
  end

  assign btn_level   = level_r;
  assign btn_press   = press_r;
  assign btn_release = release_r;
  assign led_toggle  = led_r;
  assign press_count = count_r;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench for button_debouncer with DEBOUNCE_CYCLES=8, SYNC_STAGES=2.
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b0;
  logic       btn_level;
  logic       btn_press;
  logic       btn_release;
  logic       led_toggle;
  logic [7:0] press_count;

  int n_cmp = 0;
  int n_err = 0;

  button_debouncer #(
    .DEBOUNCE_CYCLES(8),
    .SYNC_STAGES    (2),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .led_toggle (led_toggle),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits 10 edges after an input step; expects no change at edge 9 and the change at edge 10.
  task automatic expect_change(input string tag, input logic new_level);
    int pulses;
    pulses = 0;
    repeat (9) begin
      tick();
      pulses += int'(btn_press) + int'(btn_release);
    end
    check({tag, "_lvl_e9"}, 32'(btn_level), 32'(!new_level));
    check({tag, "_pulses_e9"}, 32'(pulses), 32'd0);
    tick();
    check({tag, "_lvl_e10"}, 32'(btn_level), 32'(new_level));
    check({tag, "_press_e10"}, 32'(btn_press), 32'(new_level));
    check({tag, "_rel_e10"}, 32'(btn_release), 32'(!new_level));
    tick();
    check({tag, "_pulse_gone"}, 32'(btn_press | btn_release), 32'd0);
  endtask

  task automatic press_release();
    btn_in = 1'b1;
    repeat (12) tick();
    btn_in = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    int pulses;
    int changes;

    // Reset state
    repeat (2) tick();
    check("rst_level", 32'(btn_level), 32'd0);
    check("rst_press", 32'(btn_press), 32'd0);
    check("rst_led", 32'(led_toggle), 32'd0);
    check("rst_count", 32'(press_count), 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // T2: 5-cycle glitch
    btn_in = 1'b1;
    changes = 0;
    repeat (5) begin tick(); changes += int'(btn_level) + int'(btn_press); end
    btn_in = 1'b0;
    repeat (20) begin tick(); changes += int'(btn_level) + int'(btn_press); end
    check("t2_no_change", 32'(changes), 32'd0);
    check("t2_count", 32'(press_count), 32'd0);

    // Longest ignorable glitch: 7 cycles
    btn_in = 1'b1;
    changes = 0;
    repeat (7) begin tick(); changes += int'(btn_level) + int'(btn_press); end
    btn_in = 1'b0;
    repeat (20) begin tick(); changes += int'(btn_level) + int'(btn_press); end
    check("glitch7_no_change", 32'(changes), 32'd0);

    // T1: clean press
    btn_in = 1'b1;
    expect_change("t1", 1'b1);
    check("t1_led", 32'(led_toggle), 32'd1);
    check("t1_count", 32'(press_count), 32'd1);
    repeat (9) tick();

    // T4: release
    btn_in = 1'b0;
    expect_change("t4", 1'b0);
    check("t4_led", 32'(led_toggle), 32'd1);
    check("t4_count", 32'(press_count), 32'd1);
    repeat (5) tick();

    // T3: bounce 1,1,1,0,1 then held
    btn_in = 1'b1; tick();
    btn_in = 1'b1; tick();
    btn_in = 1'b1; tick();
    btn_in = 1'b0; tick();
    btn_in = 1'b1;
    expect_change("t3", 1'b1);
    check("t3_count", 32'(press_count), 32'd2);
    check("t3_led", 32'(led_toggle), 32'd0);
    pulses = 0;
    repeat (20) begin tick(); pulses += int'(btn_press); end
    check("t3_once", 32'(pulses), 32'd0);
    btn_in = 1'b0;
    repeat (12) tick();
    check("t3_released", 32'(btn_level), 32'd0);

    // T5: 256 presses from reset wrap the counter
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 255; i++) press_release();
    check("t5_count_255", 32'(press_count), 32'd255);
    check("t5_led_255", 32'(led_toggle), 32'd1);
    press_release();
    check("t5_count_wrap", 32'(press_count), 32'd0);
    check("t5_led_wrap", 32'(led_toggle), 32'd0);
    press_release();
    check("t5_count_after", 32'(press_count), 32'd1);

    // T6: reset 4 cycles into CHECK_HIGH
    btn_in = 1'b1;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    check("t6_async_count", 32'(press_count), 32'd0);
    check("t6_async_led", 32'(led_toggle), 32'd0);
    check("t6_async_level", 32'(btn_level), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    expect_change("t6", 1'b1);
    check("t6_count", 32'(press_count), 32'd1);
    check("t6_led", 32'(led_toggle), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
